// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file: clear-engine states,
// address-width sizing and an all-zero word constant.
package reg_file_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_e;

    localparam int MAX_WIDTH = 1024;
    localparam logic [MAX_WIDTH-1:0] ZERO_WORD = '0;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_word.sv
// One storage entry of the register file: async reset, synchronous clear
// (used by the bulk-clear engine) and a load enable from the write port.
module reg_word
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: every entry carries the async reset because reset must zero the
    // whole file at once; this keeps storage in flops rather than a RAM macro.
    // NOTE: sequential state is assigned with <= so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= ZERO_WORD[WIDTH-1:0];
        end else if (clear) begin
            q <= ZERO_WORD[WIDTH-1:0];
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register file with one write port, two combinational read
// ports, optional write-to-read bypass and a sequenced bulk-clear engine.
module register_file
    import reg_file_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  DEPTH    = 32,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic [AW-1:0]    RdAddrA,
    input  logic [AW-1:0]    RdAddrB,
    output logic [WIDTH-1:0] RdDataA,
    output logic [WIDTH-1:0] RdDataB,
    input  logic             Clear,
    output logic             Busy
);

    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clr_state_e       state, state_nx;
    logic [AW-1:0]    clr_idx, clr_idx_nx;
    logic             wr_accept;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign Busy      = (state == CLEARING);
    assign wr_accept = WrEn && !Busy && ({1'b0, WrAddr} < DEPTH_W)
                       && !(ZERO_REG && (WrAddr == '0));

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_word
            logic load_i;
            logic clear_i;
            assign load_i  = wr_accept && (WrAddr == AW'(i));
            assign clear_i = Busy && (clr_idx == AW'(i));

            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (Clk),
                .rst_n (Reset),
                .load  (load_i),
                .clear (clear_i),
                .d     (WrData),
                .q     (mem_q[i])
            );
        end
    endgenerate

    // Out-of-range and hard-wired zero entries read 0 and are never bypassed.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] data;
        data = ZERO_WORD[WIDTH-1:0];
        if (({1'b0, addr} < DEPTH_W) && !(ZERO_REG && (addr == '0))) begin
            data = mem_q[addr];
            if (BYPASS && wr_accept && (WrAddr == addr)) begin
                data = WrData;
            end
        end
        return data;
    endfunction

    always_comb begin
        RdDataA = read_port(RdAddrA);
        RdDataB = read_port(RdAddrB);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    // NOTE: defaults first so every path assigns every output (no latches).
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        unique case (state)
            IDLE: begin
                if (Clear) begin
                    state_nx   = CLEARING;
                    clr_idx_nx = '0;
                end
            end
            CLEARING: begin
                if (clr_idx == LAST_IDX) begin
                    state_nx   = IDLE;
                    clr_idx_nx = '0;
                end else begin
                    clr_idx_nx = clr_idx + 1'b1;
                end
            end
            default: begin
                state_nx   = IDLE;
                clr_idx_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: three instances (default, no bypass,
// DEPTH=10/WIDTH=8) checked against an array model with a clear countdown.
module tb_register_file;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic        wr_en, clear;
    logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data;
    logic [31:0] rd_a_byp, rd_b_byp, rd_a_nb, rd_b_nb;
    logic        busy_byp, busy_nb;

    logic        s_wr_en, s_clear;
    logic [3:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b;
    logic [7:0]  s_wr_data, s_rd_a, s_rd_b;
    logic        s_busy;

    register_file u_dut (
        .Clk(Clk), .Reset(Reset), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
        .RdAddrA(rd_addr_a), .RdAddrB(rd_addr_b), .RdDataA(rd_a_byp), .RdDataB(rd_b_byp),
        .Clear(clear), .Busy(busy_byp)
    );

    register_file #(.BYPASS(1'b0)) u_dut_nb (
        .Clk(Clk), .Reset(Reset), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
        .RdAddrA(rd_addr_a), .RdAddrB(rd_addr_b), .RdDataA(rd_a_nb), .RdDataB(rd_b_nb),
        .Clear(clear), .Busy(busy_nb)
    );

    register_file #(.WIDTH(8), .DEPTH(10)) u_dut_s (
        .Clk(Clk), .Reset(Reset), .WrEn(s_wr_en), .WrAddr(s_wr_addr), .WrData(s_wr_data),
        .RdAddrA(s_rd_addr_a), .RdAddrB(s_rd_addr_b), .RdDataA(s_rd_a), .RdDataB(s_rd_b),
        .Clear(s_clear), .Busy(s_busy)
    );

    // Reference model: plain arrays plus "edges of clearing still to go".
    logic [31:0] m_mem [32];
    int          m_left;
    logic [7:0]  s_mem [10];
    int          s_left;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic bit big_accept();
        return wr_en && (m_left == 0) && (wr_addr != 5'd0);
    endfunction

    function automatic logic [31:0] big_exp(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && big_accept() && (wr_addr == a)) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit small_accept();
        return s_wr_en && (s_left == 0) && (s_wr_addr < 4'd10) && (s_wr_addr != 4'd0);
    endfunction

    function automatic logic [7:0] small_exp(input logic [3:0] a);
        if ((a == 4'd0) || (a >= 4'd10)) return 8'd0;
        if (small_accept() && (s_wr_addr == a)) return s_wr_data;
        return s_mem[a];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        for (int i = 0; i < 10; i++) s_mem[i] = '0;
        m_left = 0;
        s_left = 0;
    endfunction

    function automatic void model_edge();
        if (m_left > 0) begin
            m_mem[32 - m_left] = '0;
            m_left--;
        end else begin
            if (big_accept()) m_mem[wr_addr] = wr_data;
            if (clear) m_left = 32;
        end
        if (s_left > 0) begin
            s_mem[10 - s_left] = '0;
            s_left--;
        end else begin
            if (small_accept()) s_mem[s_wr_addr] = s_wr_data;
            if (s_clear) s_left = 10;
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; clear = 0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        s_wr_en = 0; s_clear = 0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr_a = '0; s_rd_addr_b = '0;
    endtask

    task automatic drain();
        for (int g = 0; g < 200 && (m_left != 0 || s_left != 0); g++) step();
        n_cmp++;
        if (busy_byp !== 1'b0 || s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_timeout: busy %b/%b want 0/0", busy_byp, s_busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        model_reset();
        #10;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            s_rd_addr_a = 4'(i % 16); s_rd_addr_b = 4'(15 - (i % 16));
            #1;
            n_cmp++;
            if (rd_a_byp !== 32'd0 || rd_b_byp !== 32'd0 || rd_a_nb !== 32'd0 || rd_b_nb !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_read: addr %0d got %h %h %h %h want 0", i, rd_a_byp, rd_b_byp, rd_a_nb, rd_b_nb);
            end
            n_cmp++;
            if (s_rd_a !== 8'd0 || s_rd_b !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_read_small: addr %0d got %h %h want 0", i % 16, s_rd_a, s_rd_b);
            end
        end
        n_cmp++;
        if (busy_byp !== 1'b0 || busy_nb !== 1'b0 || s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b%b%b want 000", busy_byp, busy_nb, s_busy);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr_a = 5'd5;
        step();
        wr_en = 0;
        #1;
        n_cmp++;
        if (rd_a_byp !== 32'hDEADBEEF || rd_a_nb !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_read: got %h/%h want deadbeef", rd_a_byp, rd_a_nb);
        end
        Reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (rd_a_byp !== 32'd0 || rd_a_nb !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h/%h want 0", rd_a_byp, rd_a_nb);
        end
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_zero_reg();
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        #1;
        n_cmp++;
        if (rd_a_byp !== 32'd0 || rd_b_nb !== 32'd0) begin
            n_bad++;
            $display("FAIL zero_reg_bypass: got %h/%h want 0", rd_a_byp, rd_b_nb);
        end
        step();
        wr_en = 0;
        #1;
        n_cmp++;
        if (rd_a_byp !== 32'd0 || rd_a_nb !== 32'd0) begin
            n_bad++;
            $display("FAIL zero_reg_store: got %h/%h want 0", rd_a_byp, rd_a_nb);
        end
        wr_en = 1; wr_addr = 5'd31; wr_data = 32'hA5;
        step();
        wr_en = 0; rd_addr_a = 5'd31; rd_addr_b = 5'd0;
        #1;
        n_cmp++;
        if (rd_a_byp !== 32'hA5 || rd_b_byp !== 32'd0) begin
            n_bad++;
            $display("FAIL top_entry: got %h/%h want a5/0", rd_a_byp, rd_b_byp);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'h1111;
        step();
        wr_data = 32'h55AA; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        #1;
        n_cmp++;
        if (rd_a_byp !== 32'h55AA || rd_b_byp !== 32'h55AA) begin
            n_bad++;
            $display("FAIL bypass_on: got %h/%h want 55aa", rd_a_byp, rd_b_byp);
        end
        n_cmp++;
        if (rd_a_nb !== 32'h1111 || rd_b_nb !== 32'h1111) begin
            n_bad++;
            $display("FAIL bypass_off: got %h/%h want 1111", rd_a_nb, rd_b_nb);
        end
        step();
        wr_en = 0;
        #1;
        n_cmp++;
        if (rd_a_nb !== 32'h55AA) begin
            n_bad++;
            $display("FAIL bypass_after: got %h want 55aa", rd_a_nb);
        end
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = 5'($urandom);
            wr_data   = $urandom;
            rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
            rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
            clear     = ($urandom_range(0, 59) == 0);
            s_wr_en     = ($urandom_range(0, 3) != 0);
            s_wr_addr   = 4'($urandom);
            s_wr_data   = 8'($urandom);
            s_rd_addr_a = ($urandom_range(0, 2) == 0) ? s_wr_addr : 4'($urandom);
            s_rd_addr_b = 4'($urandom);
            s_clear     = ($urandom_range(0, 29) == 0);
            #1;
            n_cmp++;
            if (rd_a_byp !== big_exp(rd_addr_a, 1'b1) || rd_b_byp !== big_exp(rd_addr_b, 1'b1)) begin
                n_bad++;
                $display("FAIL rand_byp: cyc %0d got %h %h want %h %h", c, rd_a_byp, rd_b_byp,
                         big_exp(rd_addr_a, 1'b1), big_exp(rd_addr_b, 1'b1));
            end
            n_cmp++;
            if (rd_a_nb !== big_exp(rd_addr_a, 1'b0) || rd_b_nb !== big_exp(rd_addr_b, 1'b0)) begin
                n_bad++;
                $display("FAIL rand_nb: cyc %0d got %h %h want %h %h", c, rd_a_nb, rd_b_nb,
                         big_exp(rd_addr_a, 1'b0), big_exp(rd_addr_b, 1'b0));
            end
            n_cmp++;
            if (busy_byp !== (m_left != 0) || busy_nb !== (m_left != 0) || s_busy !== (s_left != 0)) begin
                n_bad++;
                $display("FAIL rand_busy: cyc %0d got %b%b%b want %b%b%b", c, busy_byp, busy_nb, s_busy,
                         m_left != 0, m_left != 0, s_left != 0);
            end
            n_cmp++;
            if (s_rd_a !== small_exp(s_rd_addr_a) || s_rd_b !== small_exp(s_rd_addr_b)) begin
                n_bad++;
                $display("FAIL rand_small: cyc %0d got %h %h want %h %h", c, s_rd_a, s_rd_b,
                         small_exp(s_rd_addr_a), small_exp(s_rd_addr_b));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int cnt;
        drain();
        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
            step();
        end
        wr_en = 0; clear = 1;
        step();
        clear = 0;
        cnt = 0;
        while (busy_byp === 1'b1 && cnt < 100) begin
            wr_en = (cnt == 0); wr_addr = 5'd3; wr_data = 32'hFF;
            rd_addr_a = 5'd20; rd_addr_b = 5'(cnt % 32);
            #1;
            n_cmp++;
            if (rd_a_byp !== big_exp(5'd20, 1'b1) || rd_b_byp !== big_exp(rd_addr_b, 1'b1)) begin
                n_bad++;
                $display("FAIL clear_read: cyc %0d got %h %h want %h %h", cnt, rd_a_byp, rd_b_byp,
                         big_exp(5'd20, 1'b1), big_exp(rd_addr_b, 1'b1));
            end
            if (cnt == 3) begin
                n_cmp++;
                if (rd_b_byp !== 32'd3) begin
                    n_bad++;
                    $display("FAIL write_dropped: entry 3 got %h want 3", rd_b_byp);
                end
            end
            if (cnt == 10) begin
                n_cmp++;
                if (rd_a_byp !== 32'd20) begin
                    n_bad++;
                    $display("FAIL mid_clear_old: entry 20 got %h want 14", rd_a_byp);
                end
            end
            cnt++;
            step();
        end
        wr_en = 0;
        n_cmp++;
        if (cnt !== 32) begin
            n_bad++;
            $display("FAIL clear_len: busy cycles %0d want 32", cnt);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(i);
            #1;
            n_cmp++;
            if (rd_a_byp !== 32'd0 || rd_b_nb !== 32'd0) begin
                n_bad++;
                $display("FAIL cleared: entry %0d got %h/%h want 0", i, rd_a_byp, rd_b_nb);
            end
        end
    endtask

    task automatic test_clear_with_write();
        int cnt;
        drain();
        wr_en = 1; wr_addr = 5'd2; wr_data = 32'h99; clear = 1;
        step();
        wr_en = 0; clear = 0; rd_addr_a = 5'd2;
        cnt = 0;
        while (busy_byp === 1'b1 && cnt < 100) begin
            clear = (cnt == 5);
            #1;
            n_cmp++;
            if (rd_a_byp !== ((cnt < 3) ? 32'h99 : 32'd0) || rd_a_byp !== big_exp(5'd2, 1'b1)) begin
                n_bad++;
                $display("FAIL clear_write: cyc %0d got %h want %h", cnt, rd_a_byp, big_exp(5'd2, 1'b1));
            end
            cnt++;
            step();
        end
        clear = 0;
        n_cmp++;
        if (cnt !== 32) begin
            n_bad++;
            $display("FAIL clear_no_extend: busy cycles %0d want 32", cnt);
        end
    endtask

    task automatic test_small();
        drain();
        s_wr_en = 1; s_wr_addr = 4'd12; s_wr_data = 8'hAB; s_rd_addr_a = 4'd12; s_rd_addr_b = 4'd9;
        #1;
        n_cmp++;
        if (s_rd_a !== 8'd0) begin
            n_bad++;
            $display("FAIL oob_bypass: got %h want 0", s_rd_a);
        end
        step();
        s_wr_en = 0;
        #1;
        n_cmp++;
        if (s_rd_a !== 8'd0 || s_rd_b !== small_exp(4'd9)) begin
            n_bad++;
            $display("FAIL oob_write: got %h %h want 0 %h", s_rd_a, s_rd_b, small_exp(4'd9));
        end
        s_wr_en = 1; s_wr_addr = 4'd9; s_wr_data = 8'h3C;
        step();
        s_wr_en = 0; s_rd_addr_a = 4'd9;
        #1;
        n_cmp++;
        if (s_rd_a !== 8'h3C) begin
            n_bad++;
            $display("FAIL last_entry: got %h want 3c", s_rd_a);
        end
        for (int i = 1; i < 10; i++) begin
            s_wr_en = 1; s_wr_addr = 4'(i); s_wr_data = 8'(i * 17);
            wr_en = 1; wr_addr = 5'(i + 20); wr_data = 32'(i * 1000);
            step();
        end
        s_wr_en = 0; wr_en = 0; s_clear = 1; clear = 1;
        step();
        s_clear = 0; clear = 0;
        step();
        step();
        n_cmp++;
        if (s_busy !== 1'b1 || busy_byp !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_clear_busy: got %b/%b want 1/1", s_busy, busy_byp);
        end
        Reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (s_busy !== 1'b0 || busy_byp !== 1'b0 || busy_nb !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: busy %b%b%b want 000", s_busy, busy_byp, busy_nb);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); s_rd_addr_a = 4'(i % 16);
            #0.1;
            n_cmp++;
            if (rd_a_byp !== 32'd0 || rd_a_nb !== 32'd0 || s_rd_a !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_mid_clear_data: addr %0d got %h %h %h want 0", i, rd_a_byp, rd_a_nb, s_rd_a);
            end
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        step();
        n_cmp++;
        if (s_busy !== 1'b0 || busy_byp !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy %b/%b want 0/0", s_busy, busy_byp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_random(400);
        test_clear();
        test_clear_with_write();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
